// File: rtl/disaster_alert_ctrl.sv
// rtl/disaster_alert_ctrl.sv - debounced, latched four-hazard disaster alert controller
//
// Classifies flood, cyclone, earthquake and tsunami from registered sensor
// levels, debounces each hazard with a persistence counter, latches alarms
// until acknowledged and drives a registered LED vector, priority code and
// one-cycle event interrupt.
//
// Optional feature macro: DISASTER_BUZZER_EN (adds the buzzer port and divider).
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   rain     - rainfall level      [LVL_W-1:0]
//   seismic  - seismic level       [LVL_W-1:0]
//   wind     - wind level          [LVL_W-1:0]
//   sea      - sea/water level     [LVL_W-1:0]
//   mode     - 0: led shows highest-priority alarm only, 1: all alarms
//   ack      - level acknowledge, clears latched alarms
//   led      - {flood, cyclone, earthquake, tsunami}, registered
//   code     - highest-priority alarm (00 flood .. 11 tsunami), 00 when none
//   code_vld - any alarm active or latched
//   irq      - one-cycle pulse when any hazard newly becomes active
//   buzzer   - audible drive (DISASTER_BUZZER_EN only)
module disaster_alert_ctrl #(
  parameter int LVL_W    = 2,
  parameter int HI_TH    = 2,
  parameter int CRIT_TH  = 3,
  parameter int HOLD     = 4,
  parameter int BUZZ_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LVL_W-1:0] rain,
  input  logic [LVL_W-1:0] seismic,
  input  logic [LVL_W-1:0] wind,
  input  logic [LVL_W-1:0] sea,
  input  logic             mode,
  input  logic             ack,
  output logic [3:0]       led,
  output logic [1:0]       code,
  output logic             code_vld,
  output logic             irq
`ifdef DISASTER_BUZZER_EN
  ,
  output logic             buzzer
`endif
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [LVL_W-1:0] HI   = LVL_W'(HI_TH);
  localparam logic [LVL_W-1:0] CRIT = LVL_W'(CRIT_TH);
  localparam logic [CW-1:0]    LAST = CW'(HOLD - 1);

  // Illegal parameter sets elaborate this (empty) block, making them easy to spot.
  if (HOLD < 1 || CRIT_TH < HI_TH || BUZZ_DIV < 1) begin : g_bad_params
  end

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACTIVE, S_LATCHED} haz_state_t;

  // Hazard index matches led bit: 3 flood, 2 cyclone, 1 earthquake, 0 tsunami.
  haz_state_t      state     [4];
  haz_state_t      state_nxt [4];
  logic [CW-1:0]   cnt       [4];
  logic [CW-1:0]   cnt_nxt   [4];

  logic [LVL_W-1:0] rain_q, seismic_q, wind_q, sea_q;
  logic [3:0]       raw, alarm, active, entered;
  logic [3:0]       led_d, onehot;
  logic [1:0]       code_d;
  logic             entered_q;

  assign raw[3] = (rain_q >= HI) && ((rain_q >= CRIT) || (wind_q >= HI) || (sea_q >= HI));
  assign raw[2] = (wind_q >= HI) && ((wind_q >= CRIT) || (sea_q >= HI) || (rain_q >= HI));
  assign raw[1] = (seismic_q >= HI);
  assign raw[0] = (seismic_q >= HI) && (sea_q >= HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rain_q    <= '0;
      seismic_q <= '0;
      wind_q    <= '0;
      sea_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      rain_q    <= rain;
      seismic_q <= seismic;
      wind_q    <= wind;
      sea_q     <= sea;
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      entered[i]   = 1'b0;
      case (state[i])
        S_IDLE: begin
          if (raw[i]) begin
            if (HOLD == 1) begin
              state_nxt[i] = S_ACTIVE;
              entered[i]   = 1'b1;
            end else begin
              state_nxt[i] = S_PEND;
              cnt_nxt[i]   = CW'(1);
            end
          end
        end
        S_PEND: begin
          if (!raw[i]) begin
            state_nxt[i] = S_IDLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == LAST) begin
            state_nxt[i] = S_ACTIVE;
            cnt_nxt[i]   = '0;
            entered[i]   = 1'b1;
          end else begin
            cnt_nxt[i] = cnt[i] + CW'(1);
          end
        end
        S_ACTIVE: begin
          if (!raw[i]) state_nxt[i] = S_LATCHED;
        end
        S_LATCHED: begin
          // A returning condition wins over a simultaneous ack and re-arms without irq.
          if (raw[i])   state_nxt[i] = S_ACTIVE;
          else if (ack) state_nxt[i] = S_IDLE;
        end
        default: begin
          state_nxt[i] = S_IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
      active[i] = (state[i] == S_ACTIVE);
      alarm[i]  = (state[i] == S_ACTIVE) || (state[i] == S_LATCHED);
    end
  end

  always_comb begin
    code_d = 2'b00;
    onehot = 4'b0000;
    if (alarm[3]) begin
      code_d = 2'b00;
      onehot = 4'b1000;
    end else if (alarm[2]) begin
      code_d = 2'b01;
      onehot = 4'b0100;
    end else if (alarm[1]) begin
      code_d = 2'b10;
      onehot = 4'b0010;
    end else if (alarm[0]) begin
      code_d = 2'b11;
      onehot = 4'b0001;
    end
    led_d = mode ? alarm : onehot;
  end

  // entered_q delays the activation event one stage so irq lines up with led.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led       <= 4'b0000;
      code      <= 2'b00;
      code_vld  <= 1'b0;
      entered_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      led       <= led_d;
      code      <= code_d;
      code_vld  <= |alarm;
      entered_q <= |entered;
      irq       <= entered_q;
    end
  end

`ifdef DISASTER_BUZZER_EN
  localparam int DW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BUZZ_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      buzzer  <= 1'b0;
    end else if (|active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        buzzer  <= ~buzzer;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end else begin
      div_cnt <= '0;
      buzzer  <= |alarm;
    end
  end
`endif

endmodule

// File: tb/tb_disaster_alert_ctrl.sv
// tb/tb_disaster_alert_ctrl.sv - self-checking bench for disaster_alert_ctrl
module tb_disaster_alert_ctrl;

  localparam int LVL_W = 2;
  localparam int HI    = 2;
  localparam int CRIT  = 3;
  localparam int HOLD  = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rain, seismic, wind, sea;
  logic       mode, ack;
  logic [3:0] led;
  logic [1:0] code;
  logic       code_vld, irq;

  always #5 clk = ~clk;

  disaster_alert_ctrl #(
    .LVL_W(LVL_W), .HI_TH(HI), .CRIT_TH(CRIT), .HOLD(HOLD), .BUZZ_DIV(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rain(rain), .seismic(seismic), .wind(wind),
    .sea(sea), .mode(mode), .ack(ack), .led(led), .code(code),
    .code_vld(code_vld), .irq(irq)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: alarm per hazard is raised after HOLD consecutive sampled edges of
  // the condition, holds while the condition lasts, then stays latched until
  // an ack arrives while the condition is absent. Outputs follow one edge later.
  int         mq [4];        // 0 rain, 1 seismic, 2 wind, 3 sea (registered copies)
  bit         m_alarm [4];   // index = led bit
  bit         m_latched [4];
  int         m_run [4];
  bit         m_new;
  logic [3:0] e_led;
  logic [1:0] e_code;
  logic       e_vld, e_irq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < 4; h++) begin
        mq[h] = 0; m_alarm[h] = 0; m_latched[h] = 0; m_run[h] = 0;
      end
      m_new = 0; e_led = 4'b0; e_code = 2'b0; e_vld = 1'b0; e_irq = 1'b0;
    end else begin
      bit         rr [4];
      logic [3:0] a, top;
      a     = {m_alarm[3], m_alarm[2], m_alarm[1], m_alarm[0]};
      e_vld = |a;
      e_irq = m_new;
      m_new = 0;
      e_code = 2'd0;
      top    = 4'b0;
      for (int h = 0; h < 4; h++)
        if (a[h]) begin e_code = 2'(3 - h); top = 4'b0; top[h] = 1'b1; end
      e_led = mode ? a : top;
      rr[3] = mq[0] >= HI && (mq[0] >= CRIT || mq[2] >= HI || mq[3] >= HI);
      rr[2] = mq[2] >= HI && (mq[2] >= CRIT || mq[3] >= HI || mq[0] >= HI);
      rr[1] = mq[1] >= HI;
      rr[0] = mq[1] >= HI && mq[3] >= HI;
      for (int h = 0; h < 4; h++) begin
        if (m_alarm[h]) begin
          if (rr[h]) m_latched[h] = 0;
          else if (m_latched[h] && ack) begin m_alarm[h] = 0; m_latched[h] = 0; end
          else m_latched[h] = 1;
        end else if (rr[h]) begin
          m_run[h]++;
          if (m_run[h] >= HOLD) begin m_alarm[h] = 1; m_run[h] = 0; m_new = 1; end
        end else begin
          m_run[h] = 0;
        end
      end
      mq[0] = int'(rain); mq[1] = int'(seismic); mq[2] = int'(wind); mq[3] = int'(sea);
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("model_led", 8'(led), 8'(e_led));
      chk("model_code", 8'(code), 8'(e_code));
      chk("model_code_vld", 8'(code_vld), 8'(e_vld));
      chk("model_irq", 8'(irq), 8'(e_irq));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rain = 0; seismic = 0; wind = 0; sea = 0; mode = 1'b0; ack = 1'b0;
    step(3);
    chk("reset_led", 8'(led), 8'h0);
    chk("reset_code", 8'(code), 8'h0);
    chk("reset_vld", 8'(code_vld), 8'h0);
    chk("reset_irq", 8'(irq), 8'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step(20);
    chk("idle_led", 8'(led), 8'h0);

    // Flood debounce: captured at edge 1, active at edge 5, visible at edge 6.
    rain = 3;
    step(5);
    chk("flood_pre", 8'(led), 8'h0);
    step(1);
    chk("flood_led", 8'(led), 8'b1000);
    chk("flood_irq", 8'(irq), 8'h1);
    chk("flood_code", 8'(code), 8'h0);
    step(1);
    chk("flood_irq_once", 8'(irq), 8'h0);
    rain = 0;
    step(4);
    chk("flood_latched", 8'(led), 8'b1000);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("flood_ack_lag", 8'(led), 8'b1000);
    step(1);
    chk("flood_cleared", 8'(led), 8'h0);

    // Too short to pass the debounce.
    rain = 3;
    step(3);
    rain = 0;
    step(8);
    chk("flood_short", 8'(led), 8'h0);

    // Earthquake + tsunami overlap.
    seismic = 2; sea = 2;
    step(6);
    chk("overlap_led_m0", 8'(led), 8'b0010);
    chk("overlap_code", 8'(code), 8'h2);
    chk("overlap_vld", 8'(code_vld), 8'h1);
    mode = 1'b1;
    step(1);
    chk("overlap_led_m1", 8'(led), 8'b0011);
    seismic = 0; sea = 0; mode = 1'b0;
    step(4);
    ack = 1'b1;
    step(2);
    ack = 1'b0;
    step(1);
    chk("overlap_cleared", 8'(led), 8'h0);
    chk("overlap_vld_clr", 8'(code_vld), 8'h0);

    // Cyclone latch and ack.
    wind = 3;
    step(6);
    chk("cyc_led", 8'(led), 8'b0100);
    chk("cyc_code", 8'(code), 8'h1);
    wind = 0;
    step(4);
    chk("cyc_latched", 8'(led), 8'b0100);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    chk("cyc_cleared", 8'(led), 8'h0);

    // Ack ignored while condition present.
    wind = 3;
    step(6);
    ack = 1'b1;
    step(3);
    ack = 1'b0;
    chk("cyc_ack_ignored", 8'(led), 8'b0100);

    // Re-trigger from LATCHED with simultaneous ack: stays alarmed, no irq.
    wind = 0;
    step(4);
    wind = 3;
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    chk("retrig_irq", 8'(irq), 8'h0);
    step(3);
    chk("retrig_led", 8'(led), 8'b0100);
    wind = 0;
    step(4);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    chk("retrig_cleared", 8'(led), 8'h0);

    // Flood and cyclone together: flood wins the code.
    rain = 3; wind = 3;
    step(6);
    chk("multi_code", 8'(code), 8'h0);
    chk("multi_led_m0", 8'(led), 8'b1000);
    mode = 1'b1;
    step(1);
    chk("multi_led_m1", 8'(led), 8'b1100);
    rain = 0; wind = 0; mode = 1'b0;
    step(4);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(2);
    chk("multi_cleared", 8'(led), 8'h0);

    // Reset mid-PEND: debounce restarts after release.
    rain = 3;
    step(2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("rst_pend_pre", 8'(led), 8'h0);
    step(1);
    chk("rst_pend_led", 8'(led), 8'b1000);
    chk("rst_pend_irq", 8'(irq), 8'h1);

    // Reset mid-ACTIVE clears immediately.
    step(2);
    rst_n = 1'b0;
    #1;
    chk("rst_act_led", 8'(led), 8'h0);
    chk("rst_act_vld", 8'(code_vld), 8'h0);
    chk("rst_act_irq", 8'(irq), 8'h0);
    step(1);
    rain = 0;
    rst_n = 1'b1;
    step(10);
    chk("rst_act_after", 8'(led), 8'h0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
